// File: rtl/dt_preimage_search.sv
// Sweeps every feature vector through an external classifier and reports which
// inputs produce a masked target class code: first match, last match and count.
//
// state | meaning
// IDLE  | waiting for start_i; results hold the last completed sweep
// SCAN  | issuing candidates 0 .. 2**IN_W-1, one per cycle
// DRAIN | waiting CLS_LAT cycles for in-flight classifier results
// DONE  | one-cycle completion pulse
module dt_preimage_search #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int CLS_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [OUT_W-1:0] target_i,
  input  logic [OUT_W-1:0] mask_i,
  output logic [IN_W-1:0]  cand_o,
  output logic             cand_vld_o,
  input  logic [OUT_W-1:0] cls_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [IN_W-1:0]  first_o,
  output logic [IN_W-1:0]  last_o,
  output logic [IN_W:0]    count_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [IN_W-1:0] CAND_MAX = '1;
  localparam logic [2:0]      DRN_LD   = (CLS_LAT > 0) ? 3'(CLS_LAT - 1) : 3'd0;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] tgt, msk;
  logic [2:0]       drn_cnt;
  logic             accept, kill, cand_last;
  logic             dly_vld, match;
  logic [IN_W-1:0]  dly_cand;

  assign accept    = (state == IDLE) && start_i && !abort_i;
  assign kill      = (state != IDLE) && abort_i;
  assign cand_last = (cand_o == CAND_MAX);

  always_comb begin
    state_nxt  = state;
    cand_vld_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = SCAN;
      SCAN: begin
        cand_vld_o = 1'b1;
        busy_o     = 1'b1;
        if (cand_last) state_nxt = (CLS_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (drn_cnt == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        done_o    = !abort_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand_o  <= '0;
      tgt     <= '0;
      msk     <= '0;
      drn_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tgt    <= target_i;
        msk    <= mask_i;
        cand_o <= '0;
      end else if (kill) begin
        cand_o <= '0;
      end else if (state == SCAN && !cand_last) begin
        cand_o <= cand_o + 1'b1;
      end
      // Drain counter is preloaded throughout SCAN so DRAIN lasts exactly CLS_LAT cycles.
      if (state == SCAN)
        drn_cnt <= DRN_LD;
      else if (state == DRAIN && drn_cnt != 3'd0)
        drn_cnt <= drn_cnt - 3'd1;
    end
  end

  generate
    if (CLS_LAT == 0) begin : g_comb
      assign dly_vld  = cand_vld_o;
      assign dly_cand = cand_o;
    end else begin : g_pipe
      logic            pv [CLS_LAT];
      logic [IN_W-1:0] pc [CLS_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CLS_LAT; i++) begin
            pv[i] <= 1'b0;
            pc[i] <= '0;
          end
        end else if (kill) begin
          for (int i = 0; i < CLS_LAT; i++) pv[i] <= 1'b0;
        end else begin
          pv[0] <= cand_vld_o;
          pc[0] <= cand_o;
          for (int i = 1; i < CLS_LAT; i++) begin
            pv[i] <= pv[i-1];
            pc[i] <= pc[i-1];
          end
        end
      end
      assign dly_vld  = pv[CLS_LAT-1];
      assign dly_cand = pc[CLS_LAT-1];
    end
  endgenerate

  assign match = dly_vld && (((cls_i ^ tgt) & msk) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_o <= 1'b0;
      first_o <= '0;
      last_o  <= '0;
      count_o <= '0;
    end else if (accept || kill) begin
      found_o <= 1'b0;
      first_o <= '0;
      last_o  <= '0;
      count_o <= '0;
    end else if (match) begin
      count_o <= count_o + 1'b1;
      last_o  <= dly_cand;
      if (!found_o) begin
        found_o <= 1'b1;
        first_o <= dly_cand;
      end
    end
  end

endmodule

// File: tb/tb_dt_preimage_search.sv
// Bench for dt_preimage_search: two instances (CLS_LAT 0 and 2) share stimulus;
// expected sweep results come from a whole-range model and are checked on done_o.
module tb_dt_preimage_search;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] target = '0, mask = '0;
  logic [1:0] fsel = '0;
  logic [7:0] lut [256];

  logic [7:0] cand0, cls0, first0, last0, cand2, cls2, first2, last2, d1, d2;
  logic       vld0, busy0, done0, found0, vld2, busy2, done2, found2;
  logic [8:0] cnt0, cnt2;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic       fnd;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [8:0] count;
    int         dcyc;
  } exp_t;
  exp_t q0[$], q2[$];

  dt_preimage_search #(.IN_W(8), .OUT_W(8), .CLS_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .target_i(target), .mask_i(mask), .cand_o(cand0), .cand_vld_o(vld0),
    .cls_i(cls0), .busy_o(busy0), .done_o(done0), .found_o(found0),
    .first_o(first0), .last_o(last0), .count_o(cnt0));

  dt_preimage_search #(.IN_W(8), .OUT_W(8), .CLS_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .target_i(target), .mask_i(mask), .cand_o(cand2), .cand_vld_o(vld2),
    .cls_i(cls2), .busy_o(busy2), .done_o(done2), .found_o(found2),
    .first_o(first2), .last_o(last2), .count_o(cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Classifier functions: 0 identity, 1 high nibble, 2 constant zero, 3 random table.
  function automatic logic [7:0] fx(input logic [1:0] s, input logic [7:0] x);
    case (s)
      2'd0:    return x;
      2'd1:    return x & 8'hF0;
      2'd2:    return 8'h00;
      default: return lut[x];
    endcase
  endfunction

  always_comb cls0 = fx(fsel, cand0);
  always @(posedge clk) begin
    d1 <= fx(fsel, cand2);
    d2 <= d1;
  end
  assign cls2 = d2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] s, input logic [7:0] t, input logic [7:0] m);
    exp_t e;
    e.fnd = 1'b0; e.lo = '0; e.hi = '0; e.count = '0; e.dcyc = 0;
    for (int k = 0; k < 256; k++) begin
      if (((fx(s, 8'(k)) ^ t) & m) == 8'h00) begin
        if (!e.fnd) e.lo = 8'(k);
        e.fnd = 1'b1;
        e.hi = 8'(k);
        e.count = e.count + 9'd1;
      end
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic f, input logic [7:0] lo,
                     input logic [7:0] hi, input logic [8:0] c);
    chk({nm, " done_cycle"}, 64'(cyc), 64'(e.dcyc));
    chk({nm, " found"}, 64'(f), 64'(e.fnd));
    chk({nm, " first"}, 64'(lo), 64'(e.lo));
    chk({nm, " last"}, 64'(hi), 64'(e.hi));
    chk({nm, " count"}, 64'(c), 64'(e.count));
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lat0 done_o: got unexpected pulse expected none (cycle %0d)", cyc);
      end else cmp("lat0", q0.pop_front(), found0, first0, last0, cnt0);
    end
    if (done2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lat2 done_o: got unexpected pulse expected none (cycle %0d)", cyc);
      end else cmp("lat2", q2.pop_front(), found2, first2, last2, cnt2);
    end
  end

  task automatic go(input logic [1:0] s, input logic [7:0] t, input logic [7:0] m, input bit push);
    exp_t e;
    @(posedge clk); #1;
    fsel = s; target = t; mask = m; start = 1'b1;
    if (push) begin
      e = model(s, t, m);
      e.dcyc = cyc + 1 + 256; q0.push_back(e);
      e.dcyc = cyc + 1 + 258; q2.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; target = 8'($urandom); mask = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (q0.size() == 0 && q2.size() == 0 && !busy0 && !busy2 && !done0 && !done2) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle: got busy/pending after 1500 cycles expected idle");
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " lat0 outputs"}, {cand0, vld0, busy0, done0, found0, first0, last0, cnt0}, '0);
    chk({nm, " lat2 outputs"}, {cand2, vld2, busy2, done2, found2, first2, last2, cnt2}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c;
    foreach (lut[i]) lut[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    go(2'd0, 8'h5A, 8'hFF, 1'b1); wait_idle();
    go(2'd1, 8'h30, 8'hFF, 1'b1); wait_idle();
    go(2'd0, 8'($urandom), 8'h00, 1'b1); wait_idle();
    go(2'd0, 8'h01, 8'h01, 1'b1); wait_idle();
    go(2'd2, 8'h80, 8'h80, 1'b1); wait_idle();
    repeat (3) begin
      foreach (lut[i]) lut[i] = 8'($urandom);
      go(2'd3, 8'($urandom), 8'($urandom | $urandom), 1'b1); wait_idle();
    end

    // start while busy must be ignored
    go(2'd0, 8'h5A, 8'hFF, 1'b1);
    repeat (50) @(posedge clk);
    #1 start = 1'b1; target = 8'h11; mask = 8'hFF;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // start held high: ignored in DONE, accepted the following IDLE cycle
    @(posedge clk); #1;
    fsel = 2'd1; target = 8'h30; mask = 8'hF0; start = 1'b1;
    c = cyc + 1;
    e = model(2'd1, 8'h30, 8'hF0);
    e.dcyc = c + 256;       q0.push_back(e);
    e.dcyc = c + 2*256 + 2; q0.push_back(e);
    e.dcyc = c + 258;       q2.push_back(e);
    e.dcyc = c + 2*258 + 2; q2.push_back(e);
    repeat (300) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // abort at SCAN cycle 100
    go(2'd0, 8'h00, 8'h00, 1'b0);
    repeat (99) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk_zero("abort_scan");

    // abort in lat0 DONE cycle (lat2 still in DRAIN)
    go(2'd0, 8'h00, 8'h00, 1'b0);
    repeat (255) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk_zero("abort_done");
    repeat (5) @(posedge clk);

    // start together with abort in IDLE
    #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort busy", {busy0, vld0, busy2, vld2}, 4'b0000);

    // async reset mid-SCAN
    go(2'd0, 8'h05, 8'hFF, 1'b0);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle();

    go(2'd0, 8'hA5, 8'hFF, 1'b1); wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
